// File: rtl/alu_arbiter_pkg.sv
// alu_arbiter_pkg: shared opcodes, FSM states and settle-time limits for the ALU arbiter
package alu_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    localparam logic [1:0] ALU_OP_ADD = 2'd0;
    localparam logic [1:0] ALU_OP_SUB = 2'd1;
    localparam logic [1:0] ALU_OP_AND = 2'd2;
    localparam logic [1:0] ALU_OP_GT  = 2'd3;

    localparam int SETTLE_MIN = 1;
    localparam int SETTLE_MAX = 15;

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: combinational two-way one-hot grant, rr picks the winner on a tie
module rr_arbiter2 (
    input  logic [1:0] valid_i,
    input  logic       rr_i,
    output logic [1:0] grant_o
);

    // A lone requester always wins; a tie goes to the requester named by rr
    always_comb grant_o = (&valid_i) ? (rr_i ? 2'b10 : 2'b01) : valid_i;

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational 4-bit ALU between two valid/ready requesters
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
`ifdef USE_POWER_PINS
    inout  wire        vccd1,
    inout  wire        vssd1,
`endif
    input  logic       wb_clk_i,
    input  logic       wb_rst_i,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [3:0] req0_a,
    input  logic [3:0] req0_b,
    input  logic [1:0] req0_op,
    output logic       rsp0_valid,
    input  logic       rsp0_ready,
    output logic [3:0] rsp0_c,
    output logic       rsp0_ovf,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [3:0] req1_a,
    input  logic [3:0] req1_b,
    input  logic [1:0] req1_op,
    output logic       rsp1_valid,
    input  logic       rsp1_ready,
    output logic [3:0] rsp1_c,
    output logic       rsp1_ovf,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic       alu_ctrl0,
    output logic       alu_ctrl1,
    input  logic [3:0] alu_c,
    input  logic       alu_ovf,
    output logic       busy,
    output logic [7:0] ops_done
);

    if (SETTLE_CYCLES < SETTLE_MIN || SETTLE_CYCLES > SETTLE_MAX) begin : g_bad_settle
        $error("alu_arbiter: SETTLE_CYCLES must be within 1..15");
    end

    localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t          state_q, state_d;
    logic            rr_q, rr_d;
    logic            owner_q, owner_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [3:0]      alu_a_q, alu_a_d;
    logic [3:0]      alu_b_q, alu_b_d;
    logic [1:0]      alu_op_q, alu_op_d;
    logic [1:0][3:0] rsp_c_q, rsp_c_d;
    logic [1:0]      rsp_ovf_q, rsp_ovf_d;
    logic [7:0]      ops_done_q, ops_done_d;
    logic [1:0]      grant;
    logic            rsp_ready_sel;

    rr_arbiter2 u_rr (
        .valid_i ({req1_valid, req0_valid}),
        .rr_i    (rr_q),
        .grant_o (grant)
    );

    assign req0_ready    = grant[0] && state_q == ST_IDLE && !wb_rst_i;
    assign req1_ready    = grant[1] && state_q == ST_IDLE && !wb_rst_i;
    assign rsp0_valid    = state_q == ST_RESP && !owner_q;
    assign rsp1_valid    = state_q == ST_RESP && owner_q;
    assign rsp0_c        = rsp_c_q[0];
    assign rsp1_c        = rsp_c_q[1];
    assign rsp0_ovf      = rsp_ovf_q[0];
    assign rsp1_ovf      = rsp_ovf_q[1];
    assign alu_a         = alu_a_q;
    assign alu_b         = alu_b_q;
    assign alu_ctrl0     = alu_op_q[0];
    assign alu_ctrl1     = alu_op_q[1];
    assign busy          = state_q != ST_IDLE;
    assign ops_done      = ops_done_q;
    assign rsp_ready_sel = owner_q ? rsp1_ready : rsp0_ready;

    // Next state: accept a granted op in IDLE, count down the settle time, hold the result until taken
    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        owner_d    = owner_q;
        cnt_d      = cnt_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_op_d   = alu_op_q;
        rsp_c_d    = rsp_c_q;
        rsp_ovf_d  = rsp_ovf_q;
        ops_done_d = ops_done_q;
        case (state_q)
            ST_IDLE: if (|grant) begin
                alu_a_d  = grant[1] ? req1_a : req0_a;
                alu_b_d  = grant[1] ? req1_b : req0_b;
                alu_op_d = grant[1] ? req1_op : req0_op;
                owner_d  = grant[1];
                rr_d     = grant[0];
                cnt_d    = CNT_LOAD;
                state_d  = ST_DRIVE;
            end
            ST_DRIVE: if (cnt_q == 4'd0) begin
                rsp_c_d[owner_q]   = alu_c;
                rsp_ovf_d[owner_q] = alu_ovf;
                state_d            = ST_RESP;
            end else begin
                cnt_d = cnt_q - 4'd1;
            end
            ST_RESP: if (rsp_ready_sel) begin
                ops_done_d = ops_done_q + 8'd1;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any op in flight
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q    <= ST_IDLE;
            rr_q       <= 1'b0;
            owner_q    <= 1'b0;
            cnt_q      <= 4'd0;
            alu_a_q    <= 4'd0;
            alu_b_q    <= 4'd0;
            alu_op_q   <= 2'd0;
            rsp_c_q    <= '0;
            rsp_ovf_q  <= 2'b00;
            ops_done_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            owner_q    <= owner_d;
            cnt_q      <= cnt_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_op_q   <= alu_op_d;
            rsp_c_q    <= rsp_c_d;
            rsp_ovf_q  <= rsp_ovf_d;
            ops_done_q <= ops_done_d;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed table and corner-case sequences for alu_arbiter
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic [1:0]      req_valid, req_ready, rsp_valid, rsp_ready, rsp_ovf;
    logic [1:0][3:0] req_a, req_b, rsp_c;
    logic [1:0][1:0] req_op;
    logic [3:0]      alu_a, alu_b, alu_c;
    logic            alu_ctrl0, alu_ctrl1, alu_ovf, busy;
    logic [7:0]      ops_done;
    logic [4:0]      alu_r;

    logic [1:0]      s4_req_valid, s4_req_ready, s4_rsp_valid, s4_rsp_ready, s4_rsp_ovf;
    logic [1:0][3:0] s4_req_a, s4_req_b, s4_rsp_c;
    logic [1:0][1:0] s4_req_op;
    logic [3:0]      s4_alu_a, s4_alu_b, s4_alu_c;
    logic            s4_alu_ctrl0, s4_alu_ctrl1, s4_alu_ovf, s4_busy;
    logic [7:0]      s4_ops_done;
    logic [4:0]      s4_alu_r, ovr_val;
    logic            ovr_en;

    function automatic logic [4:0] alu_f(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
        case (op)
            ALU_OP_ADD: return {1'b0, a} + {1'b0, b};
            ALU_OP_SUB: return {1'b0, a} - {1'b0, b};
            ALU_OP_AND: return {1'b0, a & b};
            default:    return {4'd0, a > b};
        endcase
    endfunction

    always_comb alu_r = alu_f(alu_a, alu_b, {alu_ctrl1, alu_ctrl0});
    always_comb s4_alu_r = ovr_en ? ovr_val : alu_f(s4_alu_a, s4_alu_b, {s4_alu_ctrl1, s4_alu_ctrl0});
    assign alu_c      = alu_r[3:0];
    assign alu_ovf    = alu_r[4];
    assign s4_alu_c   = s4_alu_r[3:0];
    assign s4_alu_ovf = s4_alu_r[4];

    alu_arbiter #(.SETTLE_CYCLES(1)) u_dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .req0_valid(req_valid[0]), .req0_ready(req_ready[0]), .req0_a(req_a[0]), .req0_b(req_b[0]), .req0_op(req_op[0]),
        .rsp0_valid(rsp_valid[0]), .rsp0_ready(rsp_ready[0]), .rsp0_c(rsp_c[0]), .rsp0_ovf(rsp_ovf[0]),
        .req1_valid(req_valid[1]), .req1_ready(req_ready[1]), .req1_a(req_a[1]), .req1_b(req_b[1]), .req1_op(req_op[1]),
        .rsp1_valid(rsp_valid[1]), .rsp1_ready(rsp_ready[1]), .rsp1_c(rsp_c[1]), .rsp1_ovf(rsp_ovf[1]),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl0(alu_ctrl0), .alu_ctrl1(alu_ctrl1),
        .alu_c(alu_c), .alu_ovf(alu_ovf), .busy(busy), .ops_done(ops_done)
    );

    alu_arbiter #(.SETTLE_CYCLES(4)) u_dut4 (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .req0_valid(s4_req_valid[0]), .req0_ready(s4_req_ready[0]), .req0_a(s4_req_a[0]), .req0_b(s4_req_b[0]), .req0_op(s4_req_op[0]),
        .rsp0_valid(s4_rsp_valid[0]), .rsp0_ready(s4_rsp_ready[0]), .rsp0_c(s4_rsp_c[0]), .rsp0_ovf(s4_rsp_ovf[0]),
        .req1_valid(s4_req_valid[1]), .req1_ready(s4_req_ready[1]), .req1_a(s4_req_a[1]), .req1_b(s4_req_b[1]), .req1_op(s4_req_op[1]),
        .rsp1_valid(s4_rsp_valid[1]), .rsp1_ready(s4_rsp_ready[1]), .rsp1_c(s4_rsp_c[1]), .rsp1_ovf(s4_rsp_ovf[1]),
        .alu_a(s4_alu_a), .alu_b(s4_alu_b), .alu_ctrl0(s4_alu_ctrl0), .alu_ctrl1(s4_alu_ctrl1),
        .alu_c(s4_alu_c), .alu_ovf(s4_alu_ovf), .busy(s4_busy), .ops_done(s4_ops_done)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0; rsp_ready = '0; req_a = '0; req_b = '0; req_op = '0;
        s4_req_valid = '0; s4_rsp_ready = '0; s4_req_a = '0; s4_req_b = '0; s4_req_op = '0;
        ovr_en = 1'b0; ovr_val = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic run_op(input int r, input logic [3:0] a, input logic [3:0] b, input logic [1:0] op,
                          input logic [3:0] ec, input logic eo, input logic [7:0] exp_done);
        int n;
        logic [3:0] other_c;
        logic other_o;
        other_c = rsp_c[1-r];
        other_o = rsp_ovf[1-r];
        req_valid[r] = 1'b1; req_a[r] = a; req_b[r] = b; req_op[r] = op; rsp_ready = 2'b11;
        #1;
        n = 0;
        while (!req_ready[r] && n < 20) begin
            tick();
            n++;
        end
        chk("accept_timeout", n < 20, 1);
        tick();
        req_valid[r] = 1'b0; req_a[r] = ~a; req_op[r] = ~op;
        chk("alu_a", alu_a, a);
        chk("alu_b", alu_b, b);
        chk("alu_op", {alu_ctrl1, alu_ctrl0}, op);
        chk("busy_drive", busy, 1);
        tick();
        chk("rsp_valid_own", rsp_valid[r], 1);
        chk("rsp_valid_other", rsp_valid[1-r], 0);
        chk("rsp_c", rsp_c[r], ec);
        chk("rsp_ovf", rsp_ovf[r], eo);
        chk("other_c_kept", rsp_c[1-r], other_c);
        chk("other_ovf_kept", rsp_ovf[1-r], other_o);
        tick();
        chk("ops_done", ops_done, exp_done);
        chk("busy_idle", busy, 0);
    endtask

    typedef struct {
        int         r;
        logic [3:0] a;
        logic [3:0] b;
        logic [1:0] op;
        logic [3:0] ec;
        logic       eo;
    } vec_t;

    vec_t vecs[8];
    int   grants[$];

    initial begin
        vecs[0] = '{0, 4'd9,  4'd8,  ALU_OP_ADD, 4'd1,  1'b1};
        vecs[1] = '{1, 4'd3,  4'd5,  ALU_OP_SUB, 4'd14, 1'b1};
        vecs[2] = '{1, 4'd12, 4'd10, ALU_OP_AND, 4'd8,  1'b0};
        vecs[3] = '{0, 4'd7,  4'd2,  ALU_OP_GT,  4'd1,  1'b0};
        vecs[4] = '{1, 4'd2,  4'd7,  ALU_OP_GT,  4'd0,  1'b0};
        vecs[5] = '{0, 4'd15, 4'd1,  ALU_OP_ADD, 4'd0,  1'b1};
        vecs[6] = '{1, 4'd5,  4'd3,  ALU_OP_SUB, 4'd2,  1'b0};
        vecs[7] = '{0, 4'd6,  4'd6,  ALU_OP_SUB, 4'd0,  1'b0};

        do_reset();
        rst = 1'b1;
        req_valid = 2'b11;
        #1;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_c", rsp_c, 0);
        chk("rst_ops_done", ops_done, 0);
        do_reset();

        for (int i = 0; i < 8; i++)
            run_op(vecs[i].r, vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].ec, vecs[i].eo, 8'(i + 1));

        do_reset();
        req_valid = 2'b11; rsp_ready = 2'b11;
        req_a[0] = 4'd7; req_b[0] = 4'd2; req_op[0] = ALU_OP_GT;
        req_a[1] = 4'd2; req_b[1] = 4'd7; req_op[1] = ALU_OP_GT;
        #1;
        for (int n = 0; n < 40 && grants.size() < 4; n++) begin
            if (req_ready[0]) grants.push_back(0);
            else if (req_ready[1]) grants.push_back(1);
            if (rsp_valid[0]) chk("alt_rsp0_c", rsp_c[0], 1);
            if (rsp_valid[1]) chk("alt_rsp1_c", rsp_c[1], 0);
            tick();
        end
        chk("alt_grant_count", grants.size(), 4);
        foreach (grants[k]) chk("alt_grant_order", grants[k], k % 2);
        req_valid = '0;

        do_reset();
        req_valid = 2'b11; rsp_ready = 2'b10;
        req_a[0] = 4'd9; req_b[0] = 4'd8; req_op[0] = ALU_OP_ADD;
        req_a[1] = 4'd3; req_b[1] = 4'd5; req_op[1] = ALU_OP_SUB;
        #1;
        chk("bp_first_grant", req_ready, 2'b01);
        tick();
        req_valid[0] = 1'b0;
        tick();
        chk("bp_rsp0_valid", rsp_valid[0], 1);
        for (int k = 0; k < 5; k++) begin
            chk("bp_rsp0_c_hold", rsp_c[0], 1);
            chk("bp_rsp0_ovf_hold", rsp_ovf[0], 1);
            chk("bp_busy", busy, 1);
            chk("bp_req1_blocked", req_ready[1], 0);
            tick();
        end
        rsp_ready[0] = 1'b1;
        #1;
        chk("bp_req1_blocked_hs", req_ready[1], 0);
        tick();
        chk("bp_req1_ready_after", req_ready[1], 1);
        chk("bp_ops_done", ops_done, 1);
        tick();
        req_valid[1] = 1'b0;
        tick();
        chk("bp_rsp1_valid", rsp_valid[1], 1);
        chk("bp_rsp1_c", rsp_c[1], 14);
        chk("bp_rsp1_ovf", rsp_ovf[1], 1);
        rsp_ready = 2'b11;
        tick();

        do_reset();
        s4_req_valid[0] = 1'b1; s4_req_a[0] = 4'd2; s4_req_b[0] = 4'd3; s4_req_op[0] = ALU_OP_ADD;
        #1;
        chk("s4_ready", s4_req_ready[0], 1);
        tick();
        s4_req_valid[0] = 1'b0; s4_req_a[0] = 4'hf;
        for (int k = 0; k < 4; k++) begin
            chk("s4_alu_a_stable", s4_alu_a, 2);
            chk("s4_alu_b_stable", s4_alu_b, 3);
            chk("s4_no_rsp_yet", s4_rsp_valid[0], 0);
            if (k == 1) begin
                ovr_en = 1'b1;
                ovr_val = 5'b1_1001;
            end
            tick();
        end
        chk("s4_rsp_valid", s4_rsp_valid[0], 1);
        chk("s4_rsp_c_late", s4_rsp_c[0], 9);
        chk("s4_rsp_ovf_late", s4_rsp_ovf[0], 1);
        ovr_en = 1'b0;
        s4_rsp_ready[0] = 1'b1;
        tick();
        chk("s4_ops_done", s4_ops_done, 1);

        do_reset();
        req_valid[0] = 1'b1; req_a[0] = 4'd9; req_b[0] = 4'd8; req_op[0] = ALU_OP_SUB; rsp_ready = 2'b11;
        tick();
        req_valid[0] = 1'b0;
        chk("ar_busy_before", busy, 1);
        #1;
        rst = 1'b1;
        #1;
        chk("ar_busy", busy, 0);
        chk("ar_alu_a", alu_a, 0);
        chk("ar_alu_op", {alu_ctrl1, alu_ctrl0}, 0);
        chk("ar_rsp_valid", rsp_valid, 0);
        chk("ar_ops_done", ops_done, 0);
        tick();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("ar_no_rsp", rsp_valid, 0);
            tick();
        end
        chk("ar_ops_done_after", ops_done, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
